// File: rtl/adc_serial_sampler.sv
// Serial ADC front end: runs CONVST/SCK/DIN/DOUT frames for an LTC2308-style part
// and averages 2^AVG_LOG2 12-bit conversions into one single-cycle-valid code.
`timescale 1ns/1ps
module adc_serial_sampler #(
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 80,
  parameter int AVG_LOG2    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  input  logic        adc_dout,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_din,
  output logic [11:0] sample,
  output logic        sample_valid,
  output logic        busy
);

  localparam int AW   = 12 + AVG_LOG2;
  localparam int NFRM = 1 << AVG_LOG2;

  localparam logic [15:0] HALF  = 16'(CLK_DIV - 1);
  localparam logic [15:0] LAST  = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] WLAST = 16'(CONV_CYCLES - 1);
  localparam logic [4:0]  FLAST = 5'(NFRM);

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    WAIT,
    SHIFT,
    ACC,
    OUT
  } state_t;

  state_t         state;
  logic [15:0]    cnt;
  logic [3:0]     bcnt;
  logic [11:0]    shreg;
  logic [11:0]    din_sh;
  logic [AW-1:0]  acc;
  logic [4:0]     frm_cnt;
  logic [2:0]     ch_q;
  logic [2:0]     cfg_ch;
  logic           cfg_valid;
  logic           dummy;

  logic [11:0]    cfg_word;
  logic [AW-1:0]  acc_sum;
  logic [4:0]     frm_nxt;

  // Config word: single-ended, channel bits, unipolar, no sleep
  assign cfg_word = {1'b1, ch_q[0], ch_q[2], ch_q[1], 1'b1, 7'b0};
  assign acc_sum  = acc + AW'(shreg);
  assign frm_nxt  = frm_cnt + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      bcnt         <= '0;
      shreg        <= '0;
      din_sh       <= '0;
      acc          <= '0;
      frm_cnt      <= '0;
      ch_q         <= '0;
      cfg_ch       <= '0;
      cfg_valid    <= 1'b0;
      dummy        <= 1'b0;
      adc_convst   <= 1'b0;
      adc_sck      <= 1'b0;
      adc_din      <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            ch_q       <= channel;
            dummy      <= !cfg_valid || (channel != cfg_ch);
            cnt        <= '0;
            adc_convst <= 1'b1;
            busy       <= 1'b1;
            state      <= CONV;
          end
        end
        CONV: begin
          if (cnt == 16'd1) begin
            cnt        <= '0;
            adc_convst <= 1'b0;
            state      <= WAIT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT: begin
          if (cnt == WLAST) begin
            cnt     <= '0;
            bcnt    <= '0;
            adc_sck <= 1'b1;
            shreg   <= {shreg[10:0], adc_dout};
            adc_din <= cfg_word[11];
            din_sh  <= {cfg_word[10:0], 1'b0};
            state   <= SHIFT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt == HALF) begin
            cnt     <= cnt + 16'd1;
            adc_sck <= 1'b0;
            adc_din <= din_sh[11];
            din_sh  <= {din_sh[10:0], 1'b0};
          end else if (cnt == LAST) begin
            cnt <= '0;
            if (bcnt == 4'd11) begin
              state <= ACC;
            end else begin
              bcnt    <= bcnt + 4'd1;
              adc_sck <= 1'b1;
              shreg   <= {shreg[10:0], adc_dout};
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ACC: begin
          cnt <= '0;
          if (dummy) begin
            dummy      <= 1'b0;
            cfg_valid  <= 1'b1;
            cfg_ch     <= ch_q;
            adc_convst <= 1'b1;
            state      <= CONV;
          end else if (frm_nxt == FLAST) begin
            sample       <= 12'(acc_sum >> AVG_LOG2);
            sample_valid <= 1'b1;
            state        <= OUT;
          end else begin
            acc        <= acc_sum;
            frm_cnt    <= frm_nxt;
            adc_convst <= 1'b1;
            state      <= CONV;
          end
        end
        OUT: begin
          acc          <= '0;
          frm_cnt      <= '0;
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_serial_sampler.sv
// Directed bench for adc_serial_sampler: ADC word model, DIN frame monitor,
// burst latency/sample checks, async reset, enable drop and full-scale averaging.
`timescale 1ns/1ps
module tb_adc_serial_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [2:0]  channel = 3'd0;
  logic        adc_dout = 1'b0;
  logic        adc_convst, adc_sck, adc_din;
  logic [11:0] sample;
  logic        sample_valid, busy;

  logic        enable16 = 1'b0;
  logic        adc_dout16 = 1'b1;
  logic        convst16, sck16, din16;
  logic [11:0] sample16;
  logic        valid16, busy16;

  always #10 clk = ~clk;

  adc_serial_sampler u_dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .channel      (channel),
    .adc_dout     (adc_dout),
    .adc_convst   (adc_convst),
    .adc_sck      (adc_sck),
    .adc_din      (adc_din),
    .sample       (sample),
    .sample_valid (sample_valid),
    .busy         (busy)
  );

  adc_serial_sampler #(.AVG_LOG2(4)) u_dut16 (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable16),
    .channel      (3'd2),
    .adc_dout     (adc_dout16),
    .adc_convst   (convst16),
    .adc_sck      (sck16),
    .adc_din      (din16),
    .sample       (sample16),
    .sample_valid (valid16),
    .busy         (busy16)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // ADC model: word loaded at CONVST, MSB ready, next bit on each SCK fall
  logic [11:0] words [0:7];
  int          wptr = 0;
  logic [11:0] cur = '0;
  int          bi = 0;

  always @(posedge adc_convst or negedge adc_sck) begin
    if (adc_convst) begin
      cur = words[wptr % 8];
      wptr++;
      bi = 11;
      adc_dout = cur[11];
    end else begin
      if (bi > 0) bi--;
      adc_dout = cur[bi];
    end
  end

  logic [11:0] exp_din = 12'h880;
  logic [11:0] din_sh = '0;
  int          din_n = 0;
  int          conv_n = 0;
  logic        sck_q = 1'b0, cv_q = 1'b0, sv_q = 1'b0;

  always @(negedge clk) begin
    if (adc_convst && !cv_q) begin
      din_n = 0;
      conv_n++;
    end
    if (adc_sck && !sck_q) begin
      din_sh = {din_sh[10:0], adc_din};
      din_n++;
      if (din_n == 12) chk("din_word", din_sh, exp_din);
    end
    if (sample_valid) chk("valid_pulse", sv_q, 1'b0);
    sck_q = adc_sck;
    cv_q  = adc_convst;
    sv_q  = sample_valid;
  end

  task automatic set_words(input logic [11:0] a, b, c, d, e);
    words[0] = a; words[1] = b; words[2] = c; words[3] = d;
    words[4] = e; words[5] = e; words[6] = e; words[7] = e;
    wptr = 0;
  endtask

  task automatic measure(input string tag, input int lat,
                         input logic [11:0] exp_s);
    int n;
    int cyc;
    n = 0;
    while (!busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    cyc = 1;
    while (!sample_valid && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_sample"}, sample, exp_s);
  endtask

  task automatic burst(input string tag, input logic [2:0] ch,
                       input int lat, input logic [11:0] exp_s,
                       input bit keep);
    @(negedge clk);
    channel = ch;
    enable  = 1'b1;
    @(negedge clk);
    measure(tag, lat, exp_s);
    if (!keep) enable = 1'b0;
  endtask

  initial begin
    int n;
    int c0;
    int idle;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_convst", adc_convst, 1'b0);
    chk("rst_sck", adc_sck, 1'b0);
    chk("rst_din", adc_din, 1'b0);
    chk("rst_sample", sample, 12'h000);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sample16", sample16, 12'h000);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_convst", adc_convst, 1'b0);

    exp_din = 12'h880;
    set_words(12'hABC, 12'hABC, 12'hABC, 12'hABC, 12'hABC);
    burst("first", 3'd0, 656, 12'hABC, 1'b0);

    repeat (50) @(negedge clk);
    chk("hold_sample", sample, 12'hABC);
    chk("hold_valid", sample_valid, 1'b0);

    set_words(12'h100, 12'h101, 12'h102, 12'h103, 12'h000);
    burst("avg", 3'd0, 525, 12'h101, 1'b0);

    exp_din = 12'hE80;
    set_words(12'h200, 12'h200, 12'h200, 12'h200, 12'h200);
    burst("chg", 3'd5, 656, 12'h200, 1'b0);

    set_words(12'h010, 12'h020, 12'h030, 12'h041, 12'h000);
    burst("same5", 3'd5, 525, 12'h028, 1'b1);

    set_words(12'h300, 12'h300, 12'h300, 12'h300, 12'h300);
    idle = 0;
    @(negedge clk);
    while (!busy && idle < 10) begin
      idle++;
      @(negedge clk);
    end
    chk("b2b_idle", idle, 1);
    fork
      measure("drop", 525, 12'h300);
      begin
        repeat (200) @(negedge clk);
        enable = 1'b0;
      end
    join
    c0 = conv_n;
    repeat (400) @(negedge clk);
    chk("drop_busy", busy, 1'b0);
    chk("drop_convst", conv_n - c0, 0);

    set_words(12'h555, 12'h555, 12'h555, 12'h555, 12'h555);
    @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!adc_sck && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("reach_shift", adc_sck, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_sck", adc_sck, 1'b0);
    chk("arst_convst", adc_convst, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_sample", sample, 12'h000);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_words(12'h123, 12'h123, 12'h123, 12'h123, 12'h123);
    burst("post_rst", 3'd5, 656, 12'h123, 1'b0);

    @(negedge clk);
    enable16 = 1'b1;
    n = 0;
    while (!busy16 && n < 20) begin
      @(negedge clk);
      n++;
    end
    n = 1;
    while (!valid16 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("fs_lat", n, 2228);
    chk("fs_sample", sample16, 12'hFFF);
    enable16 = 1'b0;
    repeat (5) @(negedge clk);
    chk("fs_busy", busy16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
